prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_INSTR, default 32, the program buffer depth in 16-bit words.
REQ-002 SHALL have parameter RST_CYCLES, default 2, the number of cycles cpu_rstz is held low per reset pulse.
REQ-003 SHALL have parameter END_INSTR, default 16'hf000, the end-of-program word.
REQ-004 SHALL have one clock and an asynchronous active-low reset; the clock is named clk and the reset is named rstz.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rstz  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle pulse that begins a load; honoured only in IDLE.
REQ-008 abort  input  1  returns the block to IDLE from any state.
REQ-009 ld_data  input  16  host program word.
REQ-010 ld_valid  input  1  ld_data is valid.
REQ-011 ld_ready  output  1  loader accepts the word this cycle.
REQ-012 pg  output  1  CPU program-mode select.
REQ-013 pg_instr  output  16  instruction word presented to the CPU.
REQ-014 cpu_rstz  output  1  active-low CPU reset.
REQ-015 busy  output  1  high in any state other than IDLE or RUN.
REQ-016 done  output  1  high in RUN.
REQ-017 err  output  1  sticky overflow flag.
REQ-018 count  output  $clog2(MAX_INSTR)+1  number of words held in the buffer, END_INSTR included.

Function
REQ-019 FSM states: IDLE, FILL, PRE_RST, BURST, RUN_RST, RUN.
REQ-020 IDLE: pg=1, cpu_rstz=1, ld_ready=0; start -> FILL, with count and err cleared.
REQ-021 FILL: ld_ready=1 while count<MAX_INSTR-1. Each word accepted on ld_valid&ld_ready is written to buf[count] and count increments.
REQ-022 FILL, on accepting END_INSTR: the word is stored, then -> PRE_RST.
REQ-023 FILL, when count reaches MAX_INSTR-1 without END_INSTR: ld_ready=0, END_INSTR is written to buf[MAX_INSTR-1], err=1, then -> PRE_RST.
REQ-024 Gaps in ld_valid during FILL SHALL be tolerated with no effect on the CPU.
REQ-025 PRE_RST: pg=1 and cpu_rstz=0 for exactly RST_CYCLES cycles, then -> BURST.
REQ-026 BURST: pg=1, cpu_rstz=1, and pg_instr=buf[k] on the k-th BURST cycle (k=0..count-1), gap-free, one word per cycle; after the last word -> RUN_RST.
REQ-027 The buffer read is prefetched during the last PRE_RST cycle, so the first BURST cycle already shows buf[0].
REQ-028 RUN_RST: pg=0, cpu_rstz=0 for RST_CYCLES cycles, then -> RUN.
REQ-029 RUN: pg=0, cpu_rstz=1, done=1; only start (restarts the load) or abort leaves this state.
REQ-030 pg_instr SHALL be 16'h0000 outside BURST.
REQ-031 pg, pg_instr, cpu_rstz, ld_ready, busy and done SHALL be registered outputs.
REQ-032 abort has priority over start and over ld_valid in the same cycle: -> IDLE next cycle, cpu_rstz=1, buffer contents don't-care.
REQ-033 start outside IDLE/RUN SHALL be ignored.
REQ-034 count SHALL never exceed MAX_INSTR.

Reset
REQ-035 With rstz=0: state=IDLE, pg=1, cpu_rstz=0, pg_instr=0, ld_ready=0, busy=0, done=0, err=0, count=0.
REQ-036 cpu_rstz SHALL return to 1 on the first clk edge after rstz deasserts.
REQ-037 rstz asserted mid-FILL or mid-BURST SHALL abandon the operation with no partial burst resumed.

Structure
REQ-038 State encoding and the END_INSTR default SHALL live in shared package mas16_pkg.
REQ-039 The buffer SHALL be a separate sub-module loader_buf: MAX_INSTR x 16 storage, synchronous write, registered read, no reset on the storage array.
REQ-040 The FSM, counters and output registers SHALL live in prog_loader.

Verification
REQ-041 start, then words 16'h1234, 16'h5678, 16'hf000 with ld_valid continuous -> count=3, RST_CYCLES cycles of cpu_rstz=0 with pg=1, then pg_instr 1234/5678/f000 on 3 consecutive cycles, RST_CYCLES cycles of pg=0 with cpu_rstz=0, then done=1.
REQ-042 Same program with ld_valid deasserted 5 cycles between words -> identical gap-free BURST sequence.
REQ-043 Send 40 non-end words with MAX_INSTR=32 -> ld_ready drops after 31 words, err=1, BURST shows 31 words then f000, count=32.
REQ-044 abort during the second BURST cycle -> IDLE next cycle, pg=1, cpu_rstz=1, pg_instr=0, busy=0.
REQ-045 rstz pulsed low mid-FILL -> all outputs at reset values; a following start reloads a program cleanly.
REQ-046 start issued in RUN -> FILL with count=0 and err=0, and pg returns to 1.

Source files
------------

// File: rtl/mas16_pkg.sv
// mas16_pkg: loader FSM state encoding and the default end-of-program word
package mas16_pkg;
  typedef enum logic [2:0] {IDLE, FILL, PRE_RST, BURST, RUN_RST, RUN} state_t;
  localparam logic [15:0] END_INSTR_DEF = 16'hf000;
endpackage

// File: rtl/loader_buf.sv
// loader_buf: DEPTHx16 program store (ports: clk/rstz, write we/waddr/wdata, registered read re/raddr/rdata, rdata is 0 when re is low)
module loader_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rstz)
    if (!rstz) rdata <= '0;
    else rdata <= re ? mem[raddr] : '0;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: buffers a host program then bursts it into the CPU (ports: clk/rstz, start/abort, host ld_data/ld_valid/ld_ready, CPU pg/pg_instr/cpu_rstz, status busy/done/err/count)
module prog_loader import mas16_pkg::*; #(
  parameter int          MAX_INSTR  = 32,
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] END_INSTR  = END_INSTR_DEF
) (
  input  logic                       clk,
  input  logic                       rstz,
  input  logic                       start,
  input  logic                       abort,
  input  logic [15:0]                ld_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  output logic                       pg,
  output logic [15:0]                pg_instr,
  output logic                       cpu_rstz,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(MAX_INSTR):0] count
);
  localparam int AW = $clog2(MAX_INSTR);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RST_CYCLES + 1);
  state_t state, nxt;
  logic [RW-1:0] rcnt;
  logic [AW-1:0] rd_idx, raddr;
  logic [CW-1:0] cnt_n;
  logic acc, full, rst_last, last, we, re, clr;
  always_comb begin
    acc = state == FILL && ld_valid && ld_ready;
    full = state == FILL && count == CW'(MAX_INSTR - 1);
    rst_last = rcnt == RW'(RST_CYCLES - 1);
    last = {1'b0, rd_idx} + CW'(1) == count;
    nxt = abort ? IDLE
        : state == IDLE ? (start ? FILL : IDLE)
        : state == FILL ? ((acc && ld_data == END_INSTR) || full ? PRE_RST : FILL)
        : state == PRE_RST ? (rst_last ? BURST : PRE_RST)
        : state == BURST ? (last ? RUN_RST : BURST)
        : state == RUN_RST ? (rst_last ? RUN : RUN_RST)
        : start ? FILL : RUN;
    we = !abort && (acc || full);
    clr = nxt == FILL && state != FILL;
    cnt_n = clr ? '0 : we ? count + CW'(1) : count;
    re = nxt == BURST;
    raddr = state == BURST ? rd_idx + AW'(1) : '0;
  end
  loader_buf #(.DEPTH(MAX_INSTR), .AW(AW)) u_buf (
    .clk(clk), .rstz(rstz), .we(we), .waddr(count[AW-1:0]),
    .wdata(full ? END_INSTR : ld_data), .re(re), .raddr(raddr), .rdata(pg_instr)
  );
  always_ff @(posedge clk or negedge rstz)
    if (!rstz) begin
      state <= IDLE;
      rcnt <= '0;
      rd_idx <= '0;
      count <= '0;
      err <= 1'b0;
      ld_ready <= 1'b0;
      pg <= 1'b1;
      cpu_rstz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      rcnt <= nxt == state && (state == PRE_RST || state == RUN_RST) ? rcnt + RW'(1) : '0;
      rd_idx <= state == BURST ? rd_idx + AW'(1) : '0;
      count <= cnt_n;
      err <= clr ? 1'b0 : err | (full && !abort);
      ld_ready <= nxt == FILL && cnt_n < CW'(MAX_INSTR - 1);
      pg <= !(nxt == RUN_RST || nxt == RUN);
      cpu_rstz <= !(nxt == PRE_RST || nxt == RUN_RST);
      busy <= !(nxt == IDLE || nxt == RUN);
      done <= nxt == RUN;
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader load, burst, overflow, abort and reset scenarios
module tb_prog_loader;
  localparam int MAX = 32;
  localparam int RC = 2;
  localparam logic [15:0] ENDW = 16'hf000;
  logic clk = 0, rstz = 0, start = 0, abort = 0, ld_valid = 0;
  logic [15:0] ld_data = 0;
  logic ld_ready, pg, cpu_rstz, busy, done, err;
  logic [15:0] pg_instr;
  logic [5:0] count;
  int checks = 0, errors = 0;
  logic [15:0] src[$], sb[$];
  always #5 clk = ~clk;
  prog_loader #(.MAX_INSTR(MAX), .RST_CYCLES(RC), .END_INSTR(ENDW)) dut (
    .clk(clk), .rstz(rstz), .start(start), .abort(abort), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .pg(pg), .pg_instr(pg_instr),
    .cpu_rstz(cpu_rstz), .busy(busy), .done(done), .err(err), .count(count)
  );
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  task automatic check_reset_vals(input string tag);
    checks++;
    if (pg !== 1 || cpu_rstz !== 0 || pg_instr !== 0 || ld_ready !== 0 || busy !== 0 || done !== 0 || err !== 0 || count !== 0) begin
      errors++;
      $display("FAIL %s: pg=%b cpu_rstz=%b pg_instr=%h ld_ready=%b busy=%b done=%b err=%b count=%0d required 1 0 0000 0 0 0 0 0",
               tag, pg, cpu_rstz, pg_instr, ld_ready, busy, done, err, count);
    end
  endtask
  task automatic test_reset;
    rstz = 0;
    #12;
    check_reset_vals("reset_state");
    @(negedge clk);
    rstz = 1;
    @(negedge clk);
    checks++;
    if (cpu_rstz !== 1 || pg !== 1 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_release: cpu_rstz=%b pg=%b busy=%b done=%b required 1 1 0 0", cpu_rstz, pg, busy, done);
    end
  endtask
  task automatic pulse_start;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (count !== 0 || err !== 0 || pg !== 1 || busy !== 1 || ld_ready !== 1 || done !== 0) begin
      errors++;
      $display("FAIL start: count=%0d err=%b pg=%b busy=%b ld_ready=%b done=%b required 0 0 1 1 1 0",
               count, err, pg, busy, ld_ready, done);
    end
  endtask
  task automatic fill(input int gap, output int acc, output logic exp_err);
    logic seen_end;
    acc = 0;
    seen_end = 0;
    sb.delete();
    foreach (src[i]) begin
      if (ld_ready !== 1'b1) break;
      ld_data = src[i];
      ld_valid = 1;
      sb.push_back(src[i]);
      acc++;
      if (src[i] == ENDW) seen_end = 1;
      @(negedge clk);
      ld_valid = 0;
      if (seen_end) break;
      if (i < src.size() - 1) repeat (gap) @(negedge clk);
    end
    ld_valid = 0;
    exp_err = !seen_end && acc == MAX - 1;
    if (exp_err) sb.push_back(ENDW);
  endtask
  task automatic check_burst(input logic exp_err);
    int n, exp_cnt;
    logic [15:0] e;
    exp_cnt = sb.size();
    n = 0;
    while (cpu_rstz !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (cpu_rstz === 1'b0 && pg === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != RC) begin
      errors++;
      $display("FAIL pre_rst_len: got %0d cycles required %0d", n, RC);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (pg_instr !== e || pg !== 1 || cpu_rstz !== 1 || busy !== 1) begin
        errors++;
        $display("FAIL burst_word: pg_instr=%h pg=%b cpu_rstz=%b busy=%b required %h 1 1 1", pg_instr, pg, cpu_rstz, busy, e);
      end
      @(negedge clk);
    end
    n = 0;
    while (cpu_rstz === 1'b0 && pg === 1'b0 && n < 20) begin
      checks++;
      if (pg_instr !== 0) begin
        errors++;
        $display("FAIL run_rst_instr: pg_instr=%h required 0000", pg_instr);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != RC) begin
      errors++;
      $display("FAIL run_rst_len: got %0d cycles required %0d", n, RC);
    end
    checks++;
    if (done !== 1 || busy !== 0 || pg !== 0 || cpu_rstz !== 1 || pg_instr !== 0) begin
      errors++;
      $display("FAIL run_state: done=%b busy=%b pg=%b cpu_rstz=%b pg_instr=%h required 1 0 0 1 0000",
               done, busy, pg, cpu_rstz, pg_instr);
    end
    checks++;
    if (count !== exp_cnt[5:0] || err !== exp_err) begin
      errors++;
      $display("FAIL status: count=%0d err=%b required %0d %b", count, err, exp_cnt, exp_err);
    end
  endtask
  task automatic test_basic;
    int acc;
    logic ee;
    src = '{16'h1234, 16'h5678, 16'hf000};
    pulse_start();
    fill(0, acc, ee);
    check_burst(ee);
  endtask
  task automatic test_gaps;
    int acc;
    logic ee;
    src = '{16'h1234, 16'h5678, 16'hf000};
    pulse_start();
    fill(5, acc, ee);
    check_burst(ee);
  endtask
  task automatic test_overflow;
    int acc;
    logic ee;
    src.delete();
    for (int i = 0; i < 40; i++) src.push_back(16'h0100 + 16'(i * 3));
    pulse_start();
    fill(0, acc, ee);
    checks++;
    if (acc != MAX - 1 || ld_ready !== 0) begin
      errors++;
      $display("FAIL overflow_accept: accepted=%0d ld_ready=%b required %0d 0", acc, ld_ready, MAX - 1);
    end
    check_burst(ee);
  endtask
  task automatic test_restart_in_run;
    int acc;
    logic ee;
    src = '{16'hbeef, 16'h0042, 16'h7777, 16'hf000};
    pulse_start();
    fill(1, acc, ee);
    check_burst(ee);
  endtask
  task automatic test_abort;
    int acc;
    logic ee;
    logic [15:0] e;
    src = '{16'h1234, 16'h5678, 16'hf000};
    pulse_start();
    fill(0, acc, ee);
    repeat (RC) @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (pg_instr !== e) begin
      errors++;
      $display("FAIL abort_first_word: pg_instr=%h required %h", pg_instr, e);
    end
    @(negedge clk);
    e = sb.pop_front();
    abort = 1;
    checks++;
    if (pg_instr !== e) begin
      errors++;
      $display("FAIL abort_second_word: pg_instr=%h required %h", pg_instr, e);
    end
    @(negedge clk);
    abort = 0;
    checks++;
    if (pg !== 1 || cpu_rstz !== 1 || pg_instr !== 0 || busy !== 0 || done !== 0 || ld_ready !== 0) begin
      errors++;
      $display("FAIL abort_idle: pg=%b cpu_rstz=%b pg_instr=%h busy=%b done=%b ld_ready=%b required 1 1 0000 0 0 0",
               pg, cpu_rstz, pg_instr, busy, done, ld_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || pg_instr !== 0 || cpu_rstz !== 1) begin
      errors++;
      $display("FAIL abort_stays_idle: busy=%b done=%b pg_instr=%h cpu_rstz=%b required 0 0 0000 1", busy, done, pg_instr, cpu_rstz);
    end
    sb.delete();
  endtask
  task automatic test_reset_mid_fill;
    int acc;
    logic ee;
    pulse_start();
    ld_data = 16'haaaa;
    ld_valid = 1;
    @(negedge clk);
    ld_data = 16'hbbbb;
    @(negedge clk);
    ld_valid = 0;
    #2 rstz = 0;
    #1 check_reset_vals("reset_mid_fill");
    @(negedge clk);
    rstz = 1;
    @(negedge clk);
    checks++;
    if (cpu_rstz !== 1 || busy !== 0 || pg_instr !== 0 || count !== 0) begin
      errors++;
      $display("FAIL reset_mid_fill_release: cpu_rstz=%b busy=%b pg_instr=%h count=%0d required 1 0 0000 0", cpu_rstz, busy, pg_instr, count);
    end
    src = '{16'h0f0f, 16'h1111, 16'h2222, 16'hf000};
    pulse_start();
    fill(0, acc, ee);
    check_burst(ee);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_restart_in_run();
    test_abort();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
